// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready write-back request bundle shared by all
// write-back sources in front of the register-file port.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file
// write port between NUM_REQ write-back sources.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave req,
  input  logic              wb_stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [SRC_W-1:0]  wb_src,
  output logic              busy
);

  logic [SRC_W-1:0]  rr_q, rr_d;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              fire;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              regwrite_q;
  logic [ADDR_W-1:0] writereg_q;
  logic [DATA_W-1:0] writedata_q;
  logic [SRC_W-1:0]  src_q;

  // first valid source scanning upward from rr_q, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    if (!rst && !wb_stall && gnt_any)
      req.req_ready = NUM_REQ'(1) << gnt_idx;
  end

  assign fire     = |req.req_ready;
  assign busy     = |req.req_valid & ~fire;
  assign sel_addr = req.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    rr_d = rr_q;
    if (fire) begin
      if (int'(gnt_idx) == NUM_REQ - 1) rr_d = '0;
      else rr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      src_q       <= '0;
    end else begin
      rr_q <= rr_d;
      // r0 writes still handshake but never assert the enable
      regwrite_q <= fire && (sel_addr != '0);
      if (fire) begin
        writereg_q  <= sel_addr;
        writedata_q <= sel_data;
        src_q       <= gnt_idx;
      end
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = writereg_q;
  assign WriteData = writedata_q;
  assign wb_src    = src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors with literal
// expectations plus a per-cycle compare against a bench model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_stall = 1'b0;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [SW-1:0] wb_src;
  logic          busy;

  logic [AW-1:0] ta [N];
  logic [DW-1:0] td [N];

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SRC_W(SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .wb_stall (wb_stall),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .wb_src   (wb_src),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.req_addr = {ta[2], ta[1], ta[0]};
    bus.req_data = {td[2], td[1], td[0]};
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Priority order is ptr, ptr+1, ... modulo N; -1 if none valid.
  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  int            m_ptr;
  logic          m_rw;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;
  int            m_src;
  bit            started = 0;

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_ptr = 0; m_rw = 0; m_wr = '0; m_wd = '0; m_src = 0;
      started = 1;
    end else begin
      g = wb_stall ? -1 : pick(m_ptr, bus.req_valid);
      m_rw = 0;
      if (g >= 0) begin
        m_wr  = ta[g];
        m_wd  = td[g];
        m_src = g;
        m_rw  = (ta[g] != 0);
        m_ptr = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (started) begin
      g  = (rst || wb_stall) ? -1 : pick(m_ptr, bus.req_valid);
      er = (g < 0) ? '0 : N'(1) << g;
      check("m_ready", 64'(bus.req_ready), 64'(er));
      check("m_busy", 64'(busy),
            64'((|bus.req_valid) && (er == 0)));
      check("m_RegWrite", 64'(RegWrite), 64'(m_rw));
      check("m_WriteReg", 64'(WriteReg), 64'(m_wr));
      check("m_WriteData", 64'(WriteData), 64'(m_wd));
      check("m_wb_src", 64'(wb_src), 64'(m_src));
    end
  end

  task automatic setv(input logic r, input logic s,
                      input logic [N-1:0] v);
    rst = r;
    wb_stall = s;
    bus.req_valid = v;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid = '0;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0;
      td[i] = '0;
    end

    // reset with everything requesting
    setv(1, 0, 3'b111);
    probe(); check("rst_ready0", 64'(bus.req_ready), 0);
    next();
    probe(); check("rst_ready1", 64'(bus.req_ready), 0);
    check("rst_busy", 64'(busy), 1);
    next();
    setv(0, 0, 3'b000);
    probe();
    check("rst_RegWrite", 64'(RegWrite), 0);
    check("rst_WriteReg", 64'(WriteReg), 0);
    check("rst_WriteData", 64'(WriteData), 0);
    check("rst_wb_src", 64'(wb_src), 0);
    next();

    // single source
    ta[1] = 5; td[1] = 32'hDEADBEEF;
    setv(0, 0, 3'b010);
    probe(); check("one_ready", 64'(bus.req_ready), 3'b010);
    next();
    setv(0, 0, 3'b000);
    probe();
    check("one_RegWrite", 64'(RegWrite), 1);
    check("one_WriteReg", 64'(WriteReg), 5);
    check("one_WriteData", 64'(WriteData), 64'h0DEADBEEF);
    check("one_wb_src", 64'(wb_src), 1);
    next();
    probe(); check("one_RegWrite_off", 64'(RegWrite), 0);
    next();

    // fairness from reset
    setv(1, 0, 3'b000);
    next();
    for (int i = 0; i < N; i++) begin
      ta[i] = AW'(i + 1);
      td[i] = 32'hA000 + i;
    end
    setv(0, 0, 3'b111);
    for (int c = 0; c < 6; c++) begin
      probe();
      check("fair_ready", 64'(bus.req_ready), 64'(1 << (c % 3)));
      if (c > 0) begin
        check("fair_RegWrite", 64'(RegWrite), 1);
        check("fair_wb_src", 64'(wb_src), 64'((c - 1) % 3));
      end
      next();
    end
    setv(0, 0, 3'b000);
    probe();
    check("fair_last_RegWrite", 64'(RegWrite), 1);
    check("fair_last_src", 64'(wb_src), 2);
    next();

    // stall after granting source 0 (pointer moves to 1)
    setv(0, 0, 3'b111);
    probe(); check("pre_stall_ready", 64'(bus.req_ready), 3'b001);
    next();
    setv(0, 1, 3'b111);
    probe();
    check("stall_ready0", 64'(bus.req_ready), 0);
    check("stall_busy0", 64'(busy), 1);
    check("stall_wb_done", 64'(RegWrite), 1);
    next();
    probe();
    check("stall_ready1", 64'(bus.req_ready), 0);
    check("stall_RegWrite", 64'(RegWrite), 0);
    next();
    setv(0, 0, 3'b111);
    probe(); check("stall_resume", 64'(bus.req_ready), 3'b010);
    next();

    // write to r0 from source 2 (pointer currently 2)
    ta[2] = 0; td[2] = 32'h1234;
    setv(0, 0, 3'b100);
    probe(); check("r0_ready", 64'(bus.req_ready), 3'b100);
    next();
    setv(0, 0, 3'b111);
    probe();
    check("r0_RegWrite", 64'(RegWrite), 0);
    check("r0_WriteReg", 64'(WriteReg), 0);
    check("r0_WriteData", 64'(WriteData), 64'h1234);
    check("r0_wb_src", 64'(wb_src), 2);
    check("r0_ptr_wrap", 64'(bus.req_ready), 3'b001);
    next();

    // reset right after a grant
    setv(0, 0, 3'b010);
    probe(); check("mid_ready", 64'(bus.req_ready), 3'b010);
    next();
    setv(1, 0, 3'b111);
    probe(); check("mid_rst_ready", 64'(bus.req_ready), 0);
    next();
    setv(0, 0, 3'b111);
    probe();
    check("mid_RegWrite", 64'(RegWrite), 0);
    check("mid_wb_src", 64'(wb_src), 0);
    check("mid_first", 64'(bus.req_ready), 3'b001);
    next();

    // pseudo-random traffic, checked by the model only
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++) begin
        ta[i] = AW'($urandom_range(0, 3));
        td[i] = $urandom;
      end
      setv(($urandom_range(0, 19) == 0),
           ($urandom_range(0, 4) == 0),
           N'($urandom_range(0, 7)));
      next();
    end
    setv(0, 0, 3'b000);
    next();
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
